// File: rtl/tx_ctrl_pkg.sv
// Shared types and constants for the transmit channel sequencer and its datapath.
package tx_ctrl_pkg;

  localparam int BURST_W       = 9;
  localparam int TIMEOUT_DEF   = 16;
  localparam int MAX_RETRY_DEF = 3;
  localparam int TIMER_W       = 8;
  localparam int RETRY_W       = 5;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SETTLE,
    OFFER,
    ADV,
    DONE,
    FAULT
  } tx_state_e;

endpackage

// File: rtl/tx_channel_ctrl_if.sv
// Host, datapath and receiver signals of the transmit channel sequencer.
interface tx_channel_ctrl_if;
  import tx_ctrl_pkg::*;

  logic               start;
  logic [BURST_W-1:0] burst_len;
  logic               rx_ack;
  logic               rx_nak;
  logic               tx_enable;
  logic               tx_clear;
  logic               tx_valid;
  logic               busy;
  logic               done;
  logic               error;
  logic [BURST_W-1:0] words_sent;

  modport master (
    input  start, burst_len, rx_ack, rx_nak,
    output tx_enable, tx_clear, tx_valid, busy, done, error, words_sent
  );

  modport slave (
    output start, burst_len, rx_ack, rx_nak,
    input  tx_enable, tx_clear, tx_valid, busy, done, error, words_sent
  );

endinterface

// File: rtl/tx_retry_timer.sv
// Per-offer timeout counter and per-word retry counter for the transmit sequencer.
module tx_retry_timer
  import tx_ctrl_pkg::*;
#(
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic clk,
  input  logic clear_n,
  input  logic i_restart,
  input  logic i_tick,
  input  logic i_nak_event,
  input  logic i_ack_event,
  output logic o_timed_out,
  output logic o_retry_exhausted
);

  logic [TIMER_W-1:0] r_timeCnt;
  logic [RETRY_W-1:0] r_retryCnt;
  logic [RETRY_W-1:0] w_retryNext;

  assign w_retryNext = r_retryCnt + RETRY_W'(1);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_timeCnt <= '0;
    end else if (i_restart) begin
      r_timeCnt <= '0;
    end else if (i_tick) begin
      r_timeCnt <= r_timeCnt + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_retryCnt <= '0;
    end else if (i_ack_event) begin
      r_retryCnt <= '0;
    end else if (i_nak_event) begin
      r_retryCnt <= w_retryNext;
    end
  end

  // exhausted means the retry about to be counted would exceed the allowance
  assign o_timed_out       = (r_timeCnt == TIMER_W'(TIMEOUT - 1));
  assign o_retry_exhausted = (w_retryNext > RETRY_W'(MAX_RETRY));

endmodule

// File: rtl/tx_channel_ctrl.sv
// Sequencer for the parity-protected transmit channel: clears and steps the datapath
// counter, offers each word over valid/ack/nak and retries naks and timeouts.
module tx_channel_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic              clk,
  input  logic              clear_n,
  tx_channel_ctrl_if.master io_chan
);

  tx_state_e          r_state;
  tx_state_e          w_nextState;
  logic [BURST_W-1:0] r_burstLen;
  logic [BURST_W-1:0] r_wordsSent;
  logic [BURST_W-1:0] w_wordsInc;
  logic               r_txEnable;
  logic               r_txClear;
  logic               r_txValid;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               w_inOffer;
  logic               w_startAccept;
  logic               w_ackEvent;
  logic               w_nakEvent;
  logic               w_retryClear;
  logic               w_timedOut;
  logic               w_retryExhausted;

  assign w_inOffer     = (r_state == OFFER);
  assign w_startAccept = (r_state == IDLE) && io_chan.start && (io_chan.burst_len != '0);
  // nak wins over ack; a timeout only counts when the receiver stayed silent
  assign w_nakEvent    = w_inOffer && (io_chan.rx_nak || (w_timedOut && !io_chan.rx_ack));
  assign w_ackEvent    = w_inOffer && io_chan.rx_ack && !io_chan.rx_nak;
  assign w_retryClear  = w_ackEvent || (r_state == IDLE);
  assign w_wordsInc    = r_wordsSent + BURST_W'(1);

  tx_retry_timer #(
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) u_timer (
    .clk               (clk),
    .clear_n           (clear_n),
    .i_restart         (!w_inOffer),
    .i_tick            (w_inOffer),
    .i_nak_event       (w_nakEvent),
    .i_ack_event       (w_retryClear),
    .o_timed_out       (w_timedOut),
    .o_retry_exhausted (w_retryExhausted)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:   if (w_startAccept) w_nextState = CLR;
      CLR:    w_nextState = SETTLE;
      SETTLE: w_nextState = OFFER;
      OFFER: begin
        if (w_nakEvent) begin
          w_nextState = w_retryExhausted ? FAULT : SETTLE;
        end else if (w_ackEvent) begin
          w_nextState = (w_wordsInc == r_burstLen) ? DONE : ADV;
        end
      end
      ADV:    w_nextState = SETTLE;
      DONE:   w_nextState = IDLE;
      FAULT:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // outputs are decoded from the next state so they line up with it, registered
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_burstLen  <= '0;
      r_wordsSent <= '0;
      r_txEnable  <= 1'b0;
      r_txClear   <= 1'b0;
      r_txValid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_txClear  <= (w_nextState == CLR);
      r_txEnable <= (w_nextState == ADV);
      r_txValid  <= (w_nextState == OFFER);
      r_done     <= (w_nextState == DONE);
      r_busy     <= (w_nextState == CLR) || (w_nextState == SETTLE) ||
                    (w_nextState == OFFER) || (w_nextState == ADV);
      if (w_startAccept) begin
        r_burstLen  <= io_chan.burst_len;
        r_wordsSent <= '0;
        r_error     <= 1'b0;
      end else begin
        if (w_ackEvent) r_wordsSent <= w_wordsInc;
        if (w_nextState == FAULT) r_error <= 1'b1;
      end
    end
  end

  assign io_chan.tx_enable  = r_txEnable;
  assign io_chan.tx_clear   = r_txClear;
  assign io_chan.tx_valid   = r_txValid;
  assign io_chan.busy       = r_busy;
  assign io_chan.done       = r_done;
  assign io_chan.error      = r_error;
  assign io_chan.words_sent = r_wordsSent;

endmodule

// File: tb/tb_tx_channel_ctrl.sv
// Directed bench for tx_channel_ctrl: one instance with default retries, one with
// MAX_RETRY=0 for the timeout fault path; a reference datapath counter tracks offers.
module tb_tx_channel_ctrl;
  import tx_ctrl_pkg::*;

  logic clk     = 1'b0;
  logic clear_n = 1'b0;

  int assertCount  = 0;
  int failCount    = 0;
  int clearCount   = 0;
  int enableCount  = 0;
  int doneCount    = 0;
  int riseCount    = 0;
  int overlapCount = 0;
  int toDoneCount  = 0;
  int dpCount      = 0;
  logic prevValid  = 1'b0;

  always #5 clk = ~clk;

  tx_channel_ctrl_if io ();
  tx_channel_ctrl_if ioTo ();

  tx_channel_ctrl #(.TIMEOUT(16), .MAX_RETRY(3)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .io_chan (io)
  );

  tx_channel_ctrl #(.TIMEOUT(16), .MAX_RETRY(0)) dutTo (
    .clk     (clk),
    .clear_n (clear_n),
    .io_chan (ioTo)
  );

  // reference datapath counter plus pulse counters, sampled at the active edge
  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      dpCount   <= 0;
      prevValid <= 1'b0;
    end else begin
      if (io.tx_clear) dpCount <= 0;
      else if (io.tx_enable) dpCount <= dpCount + 1;
      prevValid <= io.tx_valid;
      if (io.tx_valid && !prevValid) riseCount <= riseCount + 1;
      if (io.tx_clear) clearCount <= clearCount + 1;
      if (io.tx_enable) enableCount <= enableCount + 1;
      if (io.done) doneCount <= doneCount + 1;
      if (io.tx_enable && io.tx_clear) overlapCount <= overlapCount + 1;
      if (ioTo.done) toDoneCount <= toDoneCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [BURST_W-1:0] len);
    io.start     = 1'b1;
    io.burst_len = len;
    cycle();
    io.start = 1'b0;
  endtask

  task automatic ackWord();
    io.rx_ack = 1'b1;
    cycle();
    io.rx_ack = 1'b0;
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (!io.tx_valid && n < 50) begin
      cycle();
      n++;
    end
    if (!io.tx_valid) checkOutput({tag, "ValidWait"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cSnap, eSnap, dSnap, rSnap, tSnap, n, bad;
    io.start = 1'b0;   io.burst_len = '0;   io.rx_ack = 1'b0;   io.rx_nak = 1'b0;
    ioTo.start = 1'b0; ioTo.burst_len = '0; ioTo.rx_ack = 1'b0; ioTo.rx_nak = 1'b0;

    clear_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetCtrlBits", int'({io.tx_enable, io.tx_clear, io.tx_valid,
                                       io.busy, io.done, io.error}), 0);
    checkOutput("resetWordsSent", int'(io.words_sent), 0);
    clear_n = 1'b1;
    cycle();

    $display("[TB] zero-length start");
    applyStimulus(9'd0);
    checkOutput("zeroLenBusy", int'(io.busy), 0);
    checkOutput("zeroLenClear", int'(io.tx_clear), 0);
    cycle();
    checkOutput("zeroLenValid", int'(io.tx_valid), 0);

    $display("[TB] normal burst of 3, start and new length while busy");
    cSnap = clearCount; eSnap = enableCount; dSnap = doneCount;
    applyStimulus(9'd3);
    checkOutput("startClear", int'(io.tx_clear), 1);
    checkOutput("startBusy", int'(io.busy), 1);
    cycle();
    checkOutput("clearOneCycle", int'(io.tx_clear), 0);
    checkOutput("settleNoValid", int'(io.tx_valid), 0);
    cycle();
    checkOutput("firstValidLatency", int'(io.tx_valid), 1);
    for (int w = 0; w < 3; w++) begin
      waitValid("normal");
      checkOutput($sformatf("normalOffer%0d", w), dpCount, w);
      ackWord();
      checkOutput($sformatf("normalWords%0d", w), int'(io.words_sent), w + 1);
      if (w < 2) begin
        checkOutput($sformatf("normalEnable%0d", w), int'(io.tx_enable), 1);
        checkOutput($sformatf("normalNoClear%0d", w), int'(io.tx_clear), 0);
        if (w == 0) begin
          io.start     = 1'b1;
          io.burst_len = 9'd7;
        end else begin
          io.start = 1'b0;
        end
      end else begin
        checkOutput("normalDone", int'(io.done), 1);
        checkOutput("normalBusyOff", int'(io.busy), 0);
      end
    end
    cycle();
    checkOutput("doneOneCycle", int'(io.done), 0);
    checkOutput("normalClears", clearCount - cSnap, 1);
    checkOutput("normalEnables", enableCount - eSnap, 2);
    checkOutput("normalDones", doneCount - dSnap, 1);
    checkOutput("normalError", int'(io.error), 0);

    $display("[TB] nak retry on word 1, second nak with ack");
    rSnap = riseCount; eSnap = enableCount; dSnap = doneCount;
    applyStimulus(9'd2);
    waitValid("nakW0");
    checkOutput("nakOffer0", dpCount, 0);
    ackWord();
    waitValid("nakW1");
    checkOutput("nakOffer1", dpCount, 1);
    io.rx_nak = 1'b1;
    cycle();
    io.rx_nak = 1'b0;
    checkOutput("nakGapValid", int'(io.tx_valid), 0);
    checkOutput("nakNoEnable", int'(io.tx_enable), 0);
    cycle();
    checkOutput("nakReofferValid", int'(io.tx_valid), 1);
    io.rx_nak = 1'b1;
    io.rx_ack = 1'b1;
    cycle();
    io.rx_nak = 1'b0;
    io.rx_ack = 1'b0;
    checkOutput("ackNakGap", int'(io.tx_valid), 0);
    checkOutput("ackNakWords", int'(io.words_sent), 1);
    cycle();
    checkOutput("ackNakReoffer", int'(io.tx_valid), 1);
    checkOutput("nakSameWord", dpCount, 1);
    ackWord();
    checkOutput("nakDone", int'(io.done), 1);
    checkOutput("nakWords", int'(io.words_sent), 2);
    cycle();
    checkOutput("nakRises", riseCount - rSnap, 4);
    checkOutput("nakEnables", enableCount - eSnap, 1);
    checkOutput("nakDones", doneCount - dSnap, 1);

    $display("[TB] retry exhaustion with MAX_RETRY=3");
    dSnap = doneCount;
    applyStimulus(9'd1);
    waitValid("exhaust");
    for (int i = 0; i < 3; i++) begin
      io.rx_nak = 1'b1;
      io.rx_ack = (i == 1);
      cycle();
      io.rx_nak = 1'b0;
      io.rx_ack = 1'b0;
      checkOutput($sformatf("retryGap%0d", i), int'(io.tx_valid), 0);
      checkOutput($sformatf("retryNoError%0d", i), int'(io.error), 0);
      cycle();
      checkOutput($sformatf("retryReoffer%0d", i), int'(io.tx_valid), 1);
    end
    io.rx_nak = 1'b1;
    io.rx_ack = 1'b1;
    cycle();
    io.rx_nak = 1'b0;
    io.rx_ack = 1'b0;
    checkOutput("exhaustError", int'(io.error), 1);
    checkOutput("exhaustBusy", int'(io.busy), 0);
    checkOutput("exhaustDone", int'(io.done), 0);
    checkOutput("exhaustWords", int'(io.words_sent), 0);
    cycle();
    checkOutput("exhaustErrorSticky", int'(io.error), 1);
    checkOutput("exhaustNoDonePulse", doneCount - dSnap, 0);
    applyStimulus(9'd1);
    checkOutput("exhaustErrorCleared", int'(io.error), 0);
    checkOutput("exhaustRestartBusy", int'(io.busy), 1);
    waitValid("exhaustRestart");
    ackWord();
    checkOutput("exhaustRestartDone", int'(io.done), 1);
    cycle();

    $display("[TB] reset during OFFER");
    dSnap = doneCount;
    applyStimulus(9'd3);
    waitValid("rstW0");
    ackWord();
    waitValid("rstW1");
    checkOutput("rstPreWords", int'(io.words_sent), 1);
    clear_n = 1'b0;
    #1;
    checkOutput("rstCtrlBits", int'({io.tx_enable, io.tx_clear, io.tx_valid,
                                     io.busy, io.done, io.error}), 0);
    checkOutput("rstWordsSent", int'(io.words_sent), 0);
    @(posedge clk);
    #1;
    clear_n = 1'b1;
    cycle();
    checkOutput("rstIdleValid", int'(io.tx_valid), 0);
    checkOutput("rstNoDone", doneCount - dSnap, 0);
    applyStimulus(9'd2);
    checkOutput("rstRestartClear", int'(io.tx_clear), 1);
    waitValid("rstR0");
    checkOutput("rstOffer0", dpCount, 0);
    ackWord();
    waitValid("rstR1");
    checkOutput("rstOffer1", dpCount, 1);
    ackWord();
    checkOutput("rstRestartDone", int'(io.done), 1);
    checkOutput("rstRestartWords", int'(io.words_sent), 2);
    cycle();

    $display("[TB] timeout fault with MAX_RETRY=0");
    tSnap = toDoneCount;
    ioTo.start     = 1'b1;
    ioTo.burst_len = 9'd1;
    cycle();
    ioTo.start = 1'b0;
    checkOutput("toStartBusy", int'(ioTo.busy), 1);
    cycle();
    cycle();
    checkOutput("toValidRise", int'(ioTo.tx_valid), 1);
    n = 0;
    while (ioTo.tx_valid && n < 100) begin
      n++;
      cycle();
    end
    checkOutput("toOfferCycles", n, 16);
    checkOutput("toError", int'(ioTo.error), 1);
    checkOutput("toBusy", int'(ioTo.busy), 0);
    checkOutput("toDoneLow", int'(ioTo.done), 0);
    repeat (5) cycle();
    checkOutput("toErrorSticky", int'(ioTo.error), 1);
    checkOutput("toNoDone", toDoneCount - tSnap, 0);
    ioTo.start = 1'b1;
    cycle();
    ioTo.start = 1'b0;
    checkOutput("toErrorCleared", int'(ioTo.error), 0);
    checkOutput("toRestartBusy", int'(ioTo.busy), 1);
    cycle();
    cycle();
    checkOutput("toRestartValid", int'(ioTo.tx_valid), 1);
    ioTo.rx_ack = 1'b1;
    cycle();
    ioTo.rx_ack = 1'b0;
    checkOutput("toAckDone", int'(ioTo.done), 1);
    checkOutput("toAckWords", int'(ioTo.words_sent), 1);
    cycle();

    $display("[TB] maximum burst of 511");
    eSnap = enableCount; dSnap = doneCount; cSnap = clearCount;
    bad = 0;
    applyStimulus(9'd511);
    for (int w = 0; w < 511; w++) begin
      waitValid("max");
      if (dpCount != w) bad++;
      ackWord();
    end
    checkOutput("maxOfferSeqErrors", bad, 0);
    checkOutput("maxDone", int'(io.done), 1);
    checkOutput("maxWords", int'(io.words_sent), 511);
    cycle();
    checkOutput("maxEnables", enableCount - eSnap, 510);
    checkOutput("maxDones", doneCount - dSnap, 1);
    checkOutput("maxClears", clearCount - cSnap, 1);
    checkOutput("enableClearOverlap", overlapCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/tx_channel_ctrl.md
Name: tx_channel_ctrl

Overview:
Sequencer for the parity-protected transmit channel datapath. The datapath is a 9-bit counter, an odd-parity generator and a 10-bit output register.
- Drives the datapath enable and clear.
- Offers each word to a receiver with a valid/ack/nak handshake.
- Retries words that are nak'd or time out.
- Reports burst completion and fault status to the host logic.

Parameters:
- BURST_W, 9: width of burst length and word count; matches the datapath counter width.
- TIMEOUT, 16: cycles in OFFER without ack/nak before the offer counts as a nak; legal range 2..255.
- MAX_RETRY, 3: re-offers allowed per word before FAULT; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  begin a burst; sampled only in IDLE.
- burst_len  in  BURST_W  words in the burst; captured with start.
- rx_ack  in  1  receiver accepted the offered word.
- rx_nak  in  1  receiver reported a parity error on the offered word.
- tx_enable  out  1  datapath counter enable, one-cycle pulse.
- tx_clear  out  1  datapath counter clear, one-cycle pulse.
- tx_valid  out  1  datapath data_out is stable and offered.
- busy  out  1  a burst is in progress.
- done  out  1  one-cycle pulse when a burst completes.
- error  out  1  sticky fault flag; cleared by the next accepted start.
- words_sent  out  BURST_W  words acknowledged in the current or last burst.

Behaviour:
- All outputs are registered (Moore).
- Async reset value of every output is 0; the FSM is forced to IDLE and the internal counters to 0.
- States:
  - IDLE: start && burst_len!=0 -> CLR. This captures burst_len, clears error and words_sent, and sets busy. start with burst_len==0 is ignored and nothing changes.
  - CLR: tx_clear=1 for exactly one cycle -> SETTLE.
  - SETTLE: one cycle covering the datapath register load -> OFFER.
  - OFFER: tx_valid=1. The timeout counter increments each cycle.
    - rx_nak, or the timeout counter reaching TIMEOUT-1 without ack/nak: retry++. If retry<=MAX_RETRY -> SETTLE (tx_valid drops for one cycle, then re-offers the same word). Otherwise -> FAULT.
    - rx_ack without rx_nak: words_sent++ and retry=0. If words_sent+1==burst_len -> DONE, else -> ADV.
    - rx_ack and rx_nak in the same cycle: nak wins.
  - ADV: tx_enable=1 for one cycle -> SETTLE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
  - FAULT: error=1 (sticky), busy=0 for one cycle -> IDLE. done is not pulsed.
- Timeout counter resets on every entry to OFFER.
- Latency:
  - start sampled at edge E0: tx_clear high in cycle E0..E1, tx_valid rises after E2.
  - ack at edge Ek: tx_enable high in cycle Ek..Ek+1, next tx_valid rises after Ek+2.
- Words offered in a burst are datapath counts 0..burst_len-1. The controller never lets the 9-bit count wrap within a burst (max burst_len = 2^BURST_W-1).
- start while busy is ignored. burst_len changes during a burst are ignored.
- rx_ack/rx_nak outside OFFER are ignored.
- clear_n asserted mid-burst: immediate return to reset values. No done or error pulse is produced. The datapath is re-cleared by the next burst's CLR.
- tx_enable and tx_clear are never high in the same cycle.

Decomposition:
- Package tx_ctrl_pkg:
  - state enumeration: IDLE, CLR, SETTLE, OFFER, ADV, DONE, FAULT;
  - default TIMEOUT and MAX_RETRY constants;
  - the counter-width constant shared with the datapath.
- Sub-module tx_retry_timer holds the timeout counter and retry counter.
  - Inputs: restart, tick, nak_event, ack_event.
  - Outputs: timed_out, retry_exhausted.
  - The FSM stays in the top-level module.

Test Plan:
- Reset: clear_n low mid-OFFER -> all outputs 0 within the same cycle; state IDLE; next start works normally.
- Normal burst, burst_len=3, rx_ack the cycle after each tx_valid rise -> tx_clear once, tx_enable twice, words_sent counts 1,2,3, done pulses once, error=0, datapath offers counts 0,1,2.
- Nak retry, MAX_RETRY=3: nak on word 1 twice, then ack -> tx_valid shows two 1-cycle gaps, no extra tx_enable, words_sent=2 after the burst of 2, done=1.
- Timeout, TIMEOUT=16, MAX_RETRY=0: no ack/nak -> after 16 OFFER cycles FAULT, error=1 and stays set, done never pulses, busy=0; the next start clears error.
- Edge cases:
  - start with burst_len=0 -> no state change, busy stays 0.
  - start asserted while busy -> ignored.
  - rx_ack and rx_nak together -> treated as nak, retry increments.
- Max burst: burst_len=511 with immediate acks -> 510 tx_enable pulses, no count wrap, words_sent=511, done pulses once.
